ifu_fetch_controller: RTL and testbench

IFU_FETCH_CONTROLLER -- requirements
Module: ifu_fetch_controller

---
 rtl/ifu_fetch_controller.sv | 128 ++++++++++++
 tb/tb_ifu_fetch_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_controller.sv
// Instruction fetch controller: issues word reads, buffers returned
// instructions in a 2-entry FIFO, and handles redirects/flush.
module ifu_fetch_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic                  r_inflight;
  logic                  r_drop;
  logic [1:0]            r_count;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_fifo_pc   [2];
  logic [DATA_WIDTH-1:0] r_fifo_data [2];

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic [2:0] w_occ;
  logic [2:0] w_lim;

  assign instr_valid = (r_count != 2'd0);
  assign instr_pc    = r_fifo_pc[r_rd_ptr];
  assign instr_data  = r_fifo_data[r_rd_ptr];

  assign w_pop  = instr_valid & instr_ready;
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_lim  = 3'd2 + {2'b00, w_pop};

  // Room is judged on buffered + in-flight words net of this cycle's pop.
  assign w_issue = (r_state == S_FETCH) & ~redirect_valid & (w_occ < w_lim);

  assign w_push = mem_ready & r_inflight & ~r_drop & ~redirect_valid;

  assign mem_read_enable = w_issue;
  assign mem_addr        = r_pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: fetch_enable gates the FETCH state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (fetch_enable)  w_state_nxt = S_FETCH;
      S_FETCH: if (!fetch_enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PC, in-flight tracking and squash flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_drop        <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_drop     <= r_inflight;
    end else begin
      r_inflight <= w_issue;
      r_drop     <= 1'b0;
      if (w_issue) begin
        r_pc          <= r_pc + 1'b1;
        r_inflight_pc <= r_pc;
      end
    end
  end

  // FIFO occupancy and pointers; redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (redirect_valid) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_wr_ptr <= r_wr_ptr ^ w_push;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
    end
  end

  // FIFO storage; contents are qualified by r_count so need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
      r_fifo_data[r_wr_ptr] <= mem_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_controller.sv
// Bench for ifu_fetch_controller: queue-based reference model,
// directed scenarios and randomized traffic.
module tb_ifu_fetch_controller;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RESET = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_enable;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] mem_addr;
  logic          mem_read_enable;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  ifu_fetch_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC(AW'(RESET))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_addr(mem_addr),
    .mem_read_enable(mem_read_enable),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit m_fetch;
  int m_pc;
  int m_q[$];
  bit m_pend;
  int m_pend_pc;

  int deliv[$];
  int o_re[64];
  int o_addr[64];
  int o_val[64];
  int o_pc[64];
  int lc;

  bit mem_re_q;
  int mem_addr_q;
  bit spur_en;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_deliv(input string nm, input int idx, input int exp);
    if (idx >= deliv.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing delivery idx=%0d required=0x%0h",
               nm, idx, exp);
    end else begin
      chk(nm, deliv[idx], exp);
    end
  endtask

  task automatic step();
    bit e_valid;
    bit e_re;
    bit pop;
    bit push;
    @(negedge clk);
    if (!rst_n) begin
      m_fetch = 1'b0;
      m_pc    = RESET;
      m_q.delete();
      m_pend  = 1'b0;
    end
    e_valid = (m_q.size() > 0);
    pop     = e_valid && instr_ready;
    e_re    = rst_n && m_fetch && !redirect_valid &&
              (m_q.size() + int'(m_pend) - int'(pop) < 2);
    chk("instr_valid", instr_valid, e_valid);
    chk("mem_read_enable", mem_read_enable, e_re);
    chk("mem_addr", mem_addr, m_pc);
    if (e_valid) begin
      chk("instr_pc", instr_pc, m_q[0]);
      chk("instr_data", instr_data, memf(m_q[0]));
    end
    if (lc < 64) begin
      o_re[lc]   = int'(mem_read_enable);
      o_addr[lc] = int'(mem_addr);
      o_val[lc]  = int'(instr_valid);
      o_pc[lc]   = int'(instr_pc);
    end
    if (instr_valid && instr_ready) deliv.push_back(int'(instr_pc));
    mem_re_q   = mem_read_enable;
    mem_addr_q = int'(mem_addr);
    if (rst_n) begin
      push = mem_ready && m_pend && !redirect_valid;
      if (pop) void'(m_q.pop_front());
      if (redirect_valid) begin
        m_q.delete();
        m_pc   = int'(redirect_pc);
        m_pend = 1'b0;
      end else begin
        if (push) m_q.push_back(m_pend_pc);
        m_pend = e_re;
        if (e_re) begin
          m_pend_pc = m_pc;
          m_pc = (m_pc + 1) % 1024;
        end
      end
      m_fetch = fetch_enable;
    end
    @(posedge clk);
    #1;
    mem_ready = mem_re_q | (spur_en && $urandom_range(0, 3) == 0);
    mem_data  = mem_re_q ? memf(mem_addr_q) : $urandom;
    lc++;
  endtask

  int d0;

  initial begin
    rst_n = 1'b0;
    fetch_enable = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_ready = 1'b0;
    mem_data = '0;
    spur_en = 1'b0;
    m_fetch = 1'b0;
    m_pc = RESET;
    m_pend = 1'b0;
    m_pend_pc = 0;
    lc = 0;
    repeat (3) step();
    chk("rst_valid", instr_valid, 0);
    chk("rst_re", mem_read_enable, 0);
    chk("rst_addr", mem_addr, 0);

    // Streaming from reset
    rst_n = 1'b1;
    fetch_enable = 1'b1;
    instr_ready = 1'b1;
    lc = 0;
    deliv.delete();
    repeat (12) step();
    chk("a_re0", o_re[0], 0);
    chk("a_re1", o_re[1], 1);
    chk("a_addr1", o_addr[1], 0);
    chk("a_addr2", o_addr[2], 1);
    chk("a_val2", o_val[2], 0);
    chk("a_val3", o_val[3], 1);
    chk("a_pc3", o_pc[3], 0);
    chk("a_pc4", o_pc[4], 1);
    chk("a_pc5", o_pc[5], 2);

    // Back-pressure for 5 cycles
    instr_ready = 1'b0;
    lc = 0;
    repeat (5) step();
    for (int i = 0; i < 5; i++) chk("bp_re", o_re[i], 0);
    chk("bp_val", o_val[4], 1);
    chk("bp_head", o_pc[4], 9);
    instr_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 14; i++) chk_deliv("bp_seq", i, i);

    // Redirect with a read in flight
    redirect_valid = 1'b1;
    redirect_pc = AW'(10'h100);
    lc = 0;
    step();
    redirect_valid = 1'b0;
    d0 = deliv.size();
    repeat (6) step();
    chk("rd_re0", o_re[0], 0);
    chk("rd_re1", o_re[1], 1);
    chk("rd_addr1", o_addr[1], 32'h100);
    chk("rd_val1", o_val[1], 0);
    chk("rd_val2", o_val[2], 0);
    chk("rd_val3", o_val[3], 1);
    chk("rd_pc3", o_pc[3], 32'h100);
    chk_deliv("rd_first", d0, 32'h100);
    chk_deliv("rd_second", d0 + 1, 32'h101);

    // Address wrap
    redirect_valid = 1'b1;
    redirect_pc = AW'(10'h3FE);
    step();
    redirect_valid = 1'b0;
    d0 = deliv.size();
    repeat (7) step();
    chk_deliv("wrap0", d0, 32'h3FE);
    chk_deliv("wrap1", d0 + 1, 32'h3FF);
    chk_deliv("wrap2", d0 + 2, 32'h000);
    chk_deliv("wrap3", d0 + 3, 32'h001);

    // Disable with a read in flight
    fetch_enable = 1'b0;
    lc = 0;
    repeat (6) step();
    chk("off_re0", o_re[0], 1);
    for (int i = 1; i < 6; i++) chk("off_re", o_re[i], 0);
    chk("off_last", deliv[deliv.size() - 1], 5);
    chk("off_val5", o_val[5], 0);

    // Redirect while idle, then enable
    redirect_valid = 1'b1;
    redirect_pc = AW'(10'h020);
    step();
    redirect_valid = 1'b0;
    repeat (2) step();
    fetch_enable = 1'b1;
    lc = 0;
    d0 = deliv.size();
    repeat (6) step();
    chk("idle_re0", o_re[0], 0);
    chk("idle_re1", o_re[1], 1);
    chk("idle_addr1", o_addr[1], 32'h20);
    chk_deliv("idle_first", d0, 32'h20);

    // Asynchronous reset with a full buffer
    instr_ready = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_re", mem_read_enable, 0);
    chk("arst_addr", mem_addr, RESET);
    repeat (2) step();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    lc = 0;
    d0 = deliv.size();
    repeat (8) step();
    chk("rr_re0", o_re[0], 0);
    chk("rr_re1", o_re[1], 1);
    chk("rr_addr1", o_addr[1], RESET);
    chk("rr_val3", o_val[3], 1);
    chk("rr_pc3", o_pc[3], RESET);
    chk_deliv("rr_first", d0, RESET);

    // Randomized traffic
    spur_en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) fetch_enable = ~fetch_enable;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ?
                    AW'(10'h3FC + $urandom_range(0, 3)) : AW'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
